// File: rtl/trace_capture.sv
// trace_capture: execution-trace recorder for the RV32IM core.
//
// It samples NUM_CH parallel XLEN-bit debug channels into a DEPTH-entry ring
// buffer. A masked compare on channel TRIG_CH acts as the trigger. After the
// trigger, the recorder stores POST_TRIG more samples and then freezes. The
// frozen buffer is read out oldest-first, and each read takes one cycle.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   sample_valid   ch_data carries a valid sample this cycle
//   ch_data        channel k at bits [k*XLEN +: XLEN]
//   arm            one-cycle pulse that starts or restarts a capture
//   trig_value     trigger compare value
//   trig_mask      1 = bit takes part in the compare
//   rd_req         readout request (served only in DONE)
//   rd_idx         entry index, 0 = oldest stored sample
//   rd_valid       rd_data holds the result of the previous rd_req
//   rd_data        read sample; zero when rd_idx is beyond the stored count
//   state          0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   sample_count   stored samples, saturates at DEPTH
//   trig_pos       oldest-relative index of the trigger sample (valid in DONE)

// One channel's slice of the ring buffer.
// It writes synchronously, reads combinationally, and has no reset.
module trace_lane #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module trace_capture #(
  parameter int XLEN      = 32,
  parameter int NUM_CH    = 3,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int TRIG_CH   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  input  logic [NUM_CH*XLEN-1:0]     ch_data,
  input  logic                       arm,
  input  logic [XLEN-1:0]            trig_value,
  input  logic [XLEN-1:0]            trig_mask,
  input  logic                       rd_req,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       rd_valid,
  output logic [NUM_CH*XLEN-1:0]     rd_data,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     sample_count,
  output logic [$clog2(DEPTH)-1:0]   trig_pos
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} st_t;

  st_t                          st;
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                post_cnt;
  logic [CW-1:0]                cnt;

  logic [XLEN-1:0]              trig_ch;
  logic                         hit;
  logic                         we;
  logic [CW-1:0]                cnt_inc;
  logic [AW-1:0]                done_pos;
  logic [AW-1:0]                oldest;
  logic [AW-1:0]                rd_addr;
  logic                         rd_in_range;
  logic [NUM_CH-1:0][XLEN-1:0]  rd_lane;
  logic [NUM_CH-1:0][XLEN-1:0]  wr_lane;

  assign trig_ch = ch_data[TRIG_CH*XLEN +: XLEN];
  assign hit     = sample_valid & ((trig_ch & trig_mask) == (trig_value & trig_mask));

  // arm outranks any sample arriving in the same cycle, so that sample is dropped
  assign we = sample_valid & ~arm & ((st == ARMED) | (st == POST));

  assign cnt_inc = (cnt == CW'(DEPTH)) ? cnt : cnt + CW'(1);

  // Taken from the count *after* the final write, so it is valid on the DONE-entry edge
  assign done_pos = AW'(cnt_inc - CW'(1) - CW'(POST_TRIG));

  // Once the buffer has wrapped, the next slot to overwrite holds the oldest sample
  assign oldest      = (cnt == CW'(DEPTH)) ? wr_ptr : '0;
  assign rd_addr     = oldest + rd_idx;
  assign rd_in_range = {1'b0, rd_idx} < cnt;

  assign wr_lane = ch_data;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    trace_lane #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr),
      .wdata (wr_lane[k]),
      .raddr (rd_addr),
      .rdata (rd_lane[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      wr_ptr   <= '0;
      cnt      <= '0;
      post_cnt <= '0;
      trig_pos <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      // Readout port: one cycle of latency, served only while frozen
      rd_valid <= rd_req & (st == DONE);
      if (rd_req && st == DONE && rd_in_range) rd_data <= rd_lane;
      else                                     rd_data <= '0;

      if (arm) begin
        st       <= ARMED;
        wr_ptr   <= '0;
        cnt      <= '0;
        post_cnt <= '0;
      end else begin
        case (st)
          ARMED: if (sample_valid) begin
            wr_ptr <= wr_ptr + AW'(1);
            cnt    <= cnt_inc;
            if (hit) begin
              if (POST_TRIG == 0) begin
                st       <= DONE;
                trig_pos <= done_pos;
              end else begin
                st       <= POST;
                post_cnt <= AW'(POST_TRIG);
              end
            end
          end
          POST: if (sample_valid) begin
            wr_ptr   <= wr_ptr + AW'(1);
            cnt      <= cnt_inc;
            post_cnt <= post_cnt - AW'(1);
            if (post_cnt == AW'(1)) begin
              st       <= DONE;
              trig_pos <= done_pos;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state        = st;
  assign sample_count = cnt;
endmodule

// File: tb/tb_trace_capture.sv
// Testbench for trace_capture.
// The bench combines three kinds of stimulus: directed scenarios with
// table-driven readout checks, hand-written corner sequences, and randomized
// traffic. Every cycle is checked against a queue-based reference model.
module tb_trace_capture;
  localparam int XLEN = 32, NUM_CH = 3, DEPTH = 16, POST_TRIG = 8, TRIG_CH = 1;
  localparam int DW = NUM_CH*XLEN;
  localparam int AW = $clog2(DEPTH);

  logic             clk = 0;
  logic             rst_n = 1;
  logic             sample_valid = 0;
  logic [DW-1:0]    ch_data = '0;
  logic             arm = 0;
  logic [XLEN-1:0]  trig_value = '0;
  logic [XLEN-1:0]  trig_mask = '0;
  logic             rd_req = 0;
  logic [AW-1:0]    rd_idx = '0;
  logic             rd_valid;
  logic [DW-1:0]    rd_data;
  logic [1:0]       state;
  logic [AW:0]      sample_count;
  logic [AW-1:0]    trig_pos;

  trace_capture #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH),
                  .POST_TRIG(POST_TRIG), .TRIG_CH(TRIG_CH)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .ch_data(ch_data),
    .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .state(state), .sample_count(sample_count), .trig_pos(trig_pos)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: it keeps the last DEPTH samples of the current capture.
  int            m_state = 0;
  int            m_post = 0;
  int            m_total = 0;
  int            m_trig_abs = 0;
  int            m_trig_pos = 0;
  logic [DW-1:0] hist[$];

  logic [31:0]   pc_next;
  logic [DW-1:0] snap[DEPTH];

  typedef struct {
    int          idx;
    logic [31:0] pc;
    bit          zero;
  } rv_t;

  rv_t tab_a[4];
  rv_t tab_b[5];

  function automatic logic [DW-1:0] mk(input logic [31:0] pc);
    return {pc * 32'd3, pc, pc ^ 32'hA5A5_0000};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_post = 0; m_total = 0; m_trig_pos = 0; m_trig_abs = 0;
    hist.delete();
  endtask

  task automatic model_done();
    m_state = 3;
    m_trig_pos = m_trig_abs - (m_total - hist.size());
  endtask

  // Applies the current inputs for one clock, advances the model, and checks the outputs.
  task automatic step();
    bit            exp_v;
    logic [DW-1:0] exp_d;
    bit            hit;
    exp_v = (m_state == 3) && rd_req;
    exp_d = '0;
    if (exp_v && int'(rd_idx) < hist.size()) exp_d = hist[rd_idx];
    if (arm) begin
      m_state = 1; m_post = 0; m_total = 0; hist.delete();
    end else if (sample_valid && (m_state == 1 || m_state == 2)) begin
      hit = (m_state == 1) &&
            ((ch_data[TRIG_CH*XLEN +: XLEN] & trig_mask) == (trig_value & trig_mask));
      hist.push_back(ch_data);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      m_total++;
      if (hit) begin
        m_trig_abs = m_total - 1;
        if (POST_TRIG == 0) model_done();
        else begin m_state = 2; m_post = POST_TRIG; end
      end else if (m_state == 2) begin
        m_post--;
        if (m_post == 0) model_done();
      end
    end
    @(posedge clk); #1;
    chk("state", state, m_state);
    chk("sample_count", sample_count, (m_total < DEPTH) ? m_total : DEPTH);
    chk("rd_valid", rd_valid, exp_v);
    chk("rd_data", rd_data, exp_d);
    if (m_state == 3) chk("trig_pos", trig_pos, m_trig_pos);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_state", state, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_trig_pos", trig_pos, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic arm_pulse(input logic [31:0] val, input logic [31:0] mask);
    trig_value = val; trig_mask = mask;
    arm = 1; step(); arm = 0;
  endtask

  // Feeds an incrementing PC stream until DONE. With gap set, every other cycle is idle.
  task automatic feed(input int n_max, input bit gap);
    int n = 0;
    while (state != 2'd3 && n < n_max) begin
      if (gap && (n % 2 == 1)) sample_valid = 0;
      else begin
        sample_valid = 1; ch_data = mk(pc_next); pc_next += 32'd4;
      end
      step();
      n++;
    end
    sample_valid = 0;
    chk("done_reached", state, 3);
  endtask

  task automatic rd(input int idx);
    rd_req = 1; rd_idx = AW'(idx); step(); rd_req = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    tab_a[0] = '{0,  32'h0C, 0};
    tab_a[1] = '{7,  32'h28, 0};
    tab_a[2] = '{8,  32'h2C, 0};
    tab_a[3] = '{15, 32'h48, 0};
    tab_b[0] = '{0,  32'h00, 0};
    tab_b[1] = '{2,  32'h08, 0};
    tab_b[2] = '{10, 32'h28, 0};
    tab_b[3] = '{11, 32'h00, 1};
    tab_b[4] = '{15, 32'h00, 1};

    @(negedge clk);
    do_reset();

    // Without an arm, the recorder ignores samples and readout.
    for (int i = 0; i < 20; i++) begin
      sample_valid = 1; ch_data = mk(32'(i*4)); rd_req = (i % 3 == 0);
      step();
    end
    sample_valid = 0; rd_req = 0;
    chk("idle_state", state, 0);
    chk("idle_count", sample_count, 0);

    // Trigger at PC 0x28. The buffer wraps and the count saturates.
    pc_next = 0;
    arm_pulse(32'h28, 32'hFFFF_FFFF);
    feed(40, 0);
    chk("t2_count", sample_count, 16);
    chk("t2_trig_pos", trig_pos, 7);
    for (int i = 0; i < 4; i++) begin
      rd(tab_a[i].idx);
      chk("t2_rd", rd_data, tab_a[i].zero ? '0 : mk(tab_a[i].pc));
    end
    // back-to-back reads
    rd_req = 1;
    for (int i = 0; i < DEPTH; i++) begin rd_idx = AW'(i); step(); end
    rd_req = 0;

    // Trigger on the third sample, so the buffer does not wrap.
    pc_next = 0;
    arm_pulse(32'h08, 32'hFFFF_FFFF);
    feed(40, 0);
    chk("t3_count", sample_count, 11);
    chk("t3_trig_pos", trig_pos, 2);
    for (int i = 0; i < 5; i++) begin
      rd(tab_b[i].idx);
      chk("t3_rd", rd_data, tab_b[i].zero ? '0 : mk(tab_b[i].pc));
    end

    // Masked trigger. The gapped run must store the same contents as the ungapped run.
    pc_next = 0;
    arm_pulse(32'h20, 32'hFFFF_FFF0);
    feed(40, 0);
    chk("t4_trig_pos", trig_pos, 7);
    for (int i = 0; i < DEPTH; i++) begin rd(i); snap[i] = rd_data; end
    chk("t4_oldest", snap[0], mk(32'h04));
    pc_next = 0;
    arm_pulse(32'h20, 32'hFFFF_FFF0);
    feed(80, 1);
    chk("t4g_trig_pos", trig_pos, 7);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      chk("t4_gap_same", rd_data, snap[i]);
    end

    // arm during POST wins over a same-cycle hit-matching sample
    pc_next = 0;
    arm_pulse(32'h08, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1; ch_data = mk(pc_next); pc_next += 4; step();
    end
    chk("t5_in_post", state, 2);
    sample_valid = 1; ch_data = mk(32'h08); arm = 1; step(); arm = 0;
    sample_valid = 0;
    chk("t5_rearm_state", state, 1);
    chk("t5_rearm_count", sample_count, 0);
    rd(0);
    chk("t5_armed_rd_valid", rd_valid, 0);
    pc_next = 32'h1000;
    trig_value = 32'h1000;
    feed(40, 0);
    chk("t5_count", sample_count, 9);
    rd(0);
    chk("t5_rd0", rd_data, mk(32'h1000));
    rd(12);
    chk("t5_rd_stale", rd_data, '0);

    // Reset mid-POST, then run a fresh capture to completion.
    pc_next = 0;
    arm_pulse(32'h04, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1; ch_data = mk(pc_next); pc_next += 4; step();
    end
    sample_valid = 0;
    chk("t6_in_post", state, 2);
    do_reset();
    pc_next = 0;
    arm_pulse(32'h04, 32'hFFFF_FFFF);
    feed(40, 0);
    chk("t6_count", sample_count, 10);
    chk("t6_trig_pos", trig_pos, 1);
    rd(1);
    chk("t6_rd1", rd_data, mk(32'h04));

    // Randomized traffic checked cycle by cycle against the model.
    arm_pulse(32'h20, 32'hFFFF_FFFF);
    for (int i = 0; i < 1500; i++) begin
      sample_valid = ($urandom % 4) != 0;
      ch_data = {$urandom, 32'(($urandom % 16) * 4), $urandom};
      arm = ($urandom % 40) == 0;
      if (arm) begin
        trig_value = 32'(($urandom % 16) * 4);
        case ($urandom % 3)
          0: trig_mask = 32'hFFFF_FFFF;
          1: trig_mask = 32'hFFFF_FFF0;
          default: trig_mask = 32'h0;
        endcase
      end
      rd_req = $urandom % 2;
      rd_idx = AW'($urandom);
      step();
    end
    arm = 0; rd_req = 0; sample_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
